// File: rtl/mips_fetch_queue.sv
// Instruction fetch unit with a small in-order queue between instruction memory and decode.
// One request in flight at a time; redirects flush the queue and squash any in-flight response.
module mips_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk1,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready,
    output logic        halted
);

    localparam int              PW   = $clog2(DEPTH);
    localparam logic [PW:0]     FULL = (PW + 1)'(DEPTH);
    localparam logic [5:0]      HLT_OPCODE = 6'h3F;

    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pc_q    [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic [31:0]   fetch_pc;
    logic          outstanding;
    logic          discard;
    logic          hlt_pending;

    logic flush;
    logic issue;
    logic push;
    logic pop;
    logic pop_is_hlt;

    // Once halted the pipeline is frozen, so late redirects have no effect.
    always_comb begin
        flush      = redirect && !halted;
        issue      = !halted && !hlt_pending && !outstanding && !redirect && (count < FULL);
        push       = imem_rvalid && outstanding && !discard && !flush;
        pop        = out_valid && out_ready && !flush;
        pop_is_hlt = (instr_q[rd_ptr][31:26] == HLT_OPCODE);
    end

    assign out_valid = (count != '0);
    assign out_instr = instr_q[rd_ptr];
    assign out_pc    = pc_q[rd_ptr];

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            fetch_pc    <= RESET_PC;
            outstanding <= 1'b0;
            discard     <= 1'b0;
            hlt_pending <= 1'b0;
            halted      <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            imem_req <= issue;
            if (issue) begin
                imem_addr <= fetch_pc;
                fetch_pc  <= fetch_pc + 32'd1;
            end

            if (issue) begin
                outstanding <= 1'b1;
            end else if (imem_rvalid) begin
                outstanding <= 1'b0;
            end

            // A response still in flight at redirect time belongs to the old path.
            if (imem_rvalid) begin
                discard <= 1'b0;
            end else if (flush && outstanding) begin
                discard <= 1'b1;
            end

            if (push) begin
                instr_q[wr_ptr] <= imem_rdata;
                pc_q[wr_ptr]    <= imem_addr;
                wr_ptr          <= wr_ptr + 1'b1;
                if (imem_rdata[31:26] == HLT_OPCODE) begin
                    hlt_pending <= 1'b1;
                end
            end

            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (pop_is_hlt) begin
                    halted <= 1'b1;
                end
            end

            if (flush) begin
                fetch_pc    <= redirect_pc;
                hlt_pending <= 1'b0;
                rd_ptr      <= wr_ptr;
                count       <= '0;
            end else if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Directed testbench for mips_fetch_queue: in-order fetch, back-pressure, redirect,
// halt, coincident redirect/response and asynchronous reset, against a 1-cycle memory model.
module tb_mips_fetch_queue;

    logic        clk1 = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready = 1'b0;
    logic        halted;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] mem [256];

    mips_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_ready   (out_ready),
        .halted      (halted)
    );

    always #5 clk1 = ~clk1;

    // Single-cycle instruction memory: one response strobe the cycle after each request.
    always @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            imem_rvalid <= 1'b0;
            imem_rdata  <= 32'h0;
        end else begin
            imem_rvalid <= imem_req;
            imem_rdata  <= imem_req ? mem[imem_addr[7:0]] : 32'h0;
        end
    end

    task automatic stepCycle();
        @(posedge clk1);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ready);
        rst_n     = 1'b0;
        redirect  = 1'b0;
        out_ready = ready;
        stepCycle();
        stepCycle();
        rst_n = 1'b1;
    endtask

    task automatic waitValid(input string tag);
        for (int i = 0; i < 20 && !out_valid; i++) stepCycle();
        checkOutput({tag, " valid"}, 32'(out_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          reqs;
        int          bad;
        logic [31:0] exp_pc;
        logic [31:0] max_addr;
        logic        seen4;
        logic        found5;

        for (int i = 0; i < 256; i++) mem[i] = 32'h2400_0000 + 32'(i);
        mem[0] = 32'h2801000a;
        mem[1] = 32'h28020014;
        mem[2] = 32'h28030019;
        mem[8] = 32'hfc000000;

        // In-order fetch with a 1-cycle memory and an always-ready consumer.
        applyStimulus(1'b1);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        stepCycle();
        checkOutput("first req", 32'(imem_req), 32'd1);
        checkOutput("first addr", imem_addr, 32'h0);
        stepCycle();
        checkOutput("valid at N+1", 32'(out_valid), 32'd0);
        stepCycle();
        checkOutput("valid at N+2", 32'(out_valid), 32'd1);
        checkOutput("pc0", out_pc, 32'h0);
        checkOutput("instr0", out_instr, 32'h2801000a);
        stepCycle();
        waitValid("pc1");
        checkOutput("pc1", out_pc, 32'h1);
        checkOutput("instr1", out_instr, 32'h28020014);
        stepCycle();
        waitValid("pc2");
        checkOutput("pc2", out_pc, 32'h2);
        checkOutput("instr2", out_instr, 32'h28030019);

        // Back-pressure: exactly DEPTH requests, then the queue holds until drained.
        applyStimulus(1'b0);
        reqs = 0;
        bad  = 0;
        for (int i = 0; i < 40; i++) begin
            stepCycle();
            if (imem_req) begin
                if (imem_addr != 32'(reqs)) bad++;
                reqs++;
            end
        end
        checkOutput("bp request count", 32'(reqs), 32'd4);
        checkOutput("bp request order", 32'(bad), 32'd0);
        checkOutput("bp head valid", 32'(out_valid), 32'd1);
        checkOutput("bp head pc", out_pc, 32'h0);
        checkOutput("bp head instr", out_instr, 32'h2801000a);

        out_ready = 1'b1;
        exp_pc = 32'h0;
        seen4  = 1'b0;
        found5 = 1'b0;
        for (int i = 0; i < 40 && !found5; i++) begin
            if (out_valid) begin
                checkOutput("bp pop pc", out_pc, exp_pc);
                exp_pc = exp_pc + 32'd1;
            end
            stepCycle();
            if (imem_req && !seen4) begin
                checkOutput("bp next addr", imem_addr, 32'h4);
                seen4 = 1'b1;
            end
            if (imem_req && imem_addr == 32'h5) found5 = 1'b1;
        end
        checkOutput("bp addr5 issued", 32'(found5), 32'd1);
        checkOutput("bp entries popped", exp_pc, 32'h5);

        // Redirect while the addr-5 request is in flight: its response must be dropped.
        redirect    = 1'b1;
        redirect_pc = 32'h20;
        stepCycle();
        redirect = 1'b0;
        checkOutput("redir valid low", 32'(out_valid), 32'd0);
        checkOutput("redir stale rvalid", 32'(imem_rvalid), 32'd1);
        stepCycle();
        checkOutput("redir no push", 32'(out_valid), 32'd0);
        waitValid("redir");
        checkOutput("redir pc", out_pc, 32'h20);
        checkOutput("redir instr", out_instr, 32'h24000020);

        // Halt: HLT at addr 8 stops fetching and raises halted after its pop.
        applyStimulus(1'b1);
        max_addr = 32'h0;
        for (int i = 0; i < 100; i++) begin
            stepCycle();
            if (imem_req && imem_addr > max_addr) max_addr = imem_addr;
            if (out_valid && out_pc == 32'h8) break;
        end
        checkOutput("hlt head pc", out_pc, 32'h8);
        checkOutput("hlt instr", out_instr, 32'hfc000000);
        checkOutput("hlt not yet halted", 32'(halted), 32'd0);
        stepCycle();
        checkOutput("hlt halted", 32'(halted), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h20;
        stepCycle();
        redirect = 1'b0;
        for (int i = 0; i < 10; i++) begin
            stepCycle();
            if (imem_req && imem_addr > max_addr) max_addr = imem_addr;
            if (imem_req) bad++;
        end
        checkOutput("hlt sticky", 32'(halted), 32'd1);
        checkOutput("hlt no output", 32'(out_valid), 32'd0);
        checkOutput("hlt max addr", max_addr, 32'h8);

        // Redirect coinciding with a response while one entry is queued.
        applyStimulus(1'b0);
        stepCycle();
        stepCycle();
        stepCycle();
        checkOutput("coin one queued", 32'(out_valid), 32'd1);
        stepCycle();
        checkOutput("coin second req", imem_addr, 32'h1);
        stepCycle();
        checkOutput("coin rvalid", 32'(imem_rvalid), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h10;
        stepCycle();
        redirect = 1'b0;
        checkOutput("coin count zero", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        waitValid("coin");
        checkOutput("coin pc", out_pc, 32'h10);
        checkOutput("coin instr", out_instr, 32'h24000010);

        // Asynchronous reset mid-cycle with a full queue.
        applyStimulus(1'b0);
        for (int i = 0; i < 20; i++) stepCycle();
        checkOutput("ar full valid", 32'(out_valid), 32'd1);
        checkOutput("ar last addr", imem_addr, 32'h3);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("ar imem_req", 32'(imem_req), 32'd0);
        checkOutput("ar imem_addr", imem_addr, 32'h0);
        checkOutput("ar out_valid", 32'(out_valid), 32'd0);
        checkOutput("ar out_instr", out_instr, 32'h0);
        checkOutput("ar out_pc", out_pc, 32'h0);
        checkOutput("ar halted", 32'(halted), 32'd0);
        stepCycle();
        rst_n = 1'b1;
        stepCycle();
        checkOutput("ar restart req", 32'(imem_req), 32'd1);
        checkOutput("ar restart addr", imem_addr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
